// File: rtl/reg_wb_buffer.sv
// Write-back buffer: queues {rd,data} results ahead of the register file and bypasses pending values onto reads.
// Latency: a push at edge N is writable in cycle N+1. Backpressure: wb_ready_out drops only when all entries are pending.
module reg_wb_buffer #(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int REG_MEM_DEPTH_POW  = 5,
    parameter int BUF_DEPTH_POW      = 2
) (
    input  logic                                clk_in,
    input  logic                                reset,
    input  logic                                wb_valid_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]        wb_rd_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  wb_data_in,
    output logic                                wb_ready_out,
    input  logic                                drain_en_in,
    output logic                                rf_write_en,
    output logic [REG_MEM_DEPTH_POW-1:0]        rf_rd,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0]  rf_data_write,
    input  logic [REG_MEM_DEPTH_POW-1:0]        rs1_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]        rs2_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  rf_data1_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  rf_data2_in,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0]  reg_data1_out,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0]  reg_data2_out,
    output logic [BUF_DEPTH_POW:0]              count_out
);

    localparam int DW    = 1 << REG_DATA_WIDTH_POW;
    localparam int DEPTH = 1 << BUF_DEPTH_POW;
    localparam int PW    = BUF_DEPTH_POW;
    localparam int CW    = BUF_DEPTH_POW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0]                r_head;
    logic [PW-1:0]                r_tail;
    logic [CW-1:0]                r_count;
    logic [REG_MEM_DEPTH_POW-1:0] r_rd   [DEPTH];
    logic [DW-1:0]                r_data [DEPTH];

    logic [CW-1:0]                w_cnt;
    logic                         w_ready;
    logic                         w_push;
    logic                         w_pop;
    logic [PW-1:0]                w_idx;
    logic [DW-1:0]                w_byp1;
    logic [DW-1:0]                w_byp2;

    // Reset masks the occupancy so nothing stale is written or bypassed in the reset cycle itself.
    assign w_cnt   = reset ? '0 : r_count;
    assign w_ready = (w_cnt < FULL);
    assign w_push  = wb_valid_in && w_ready && (wb_rd_in != '0) && !reset;
    assign w_pop   = (w_cnt != '0) && drain_en_in;

    assign wb_ready_out  = w_ready;
    assign rf_write_en   = w_pop;
    assign rf_rd         = r_rd[r_head];
    assign rf_data_write = r_data[r_head];
    assign count_out     = w_cnt;
    assign reg_data1_out = w_byp1;
    assign reg_data2_out = w_byp2;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_rd[r_tail]   <= wb_rd_in;
            r_data[r_tail] <= wb_data_in;
        end
    end

    // Walk oldest to youngest so the last match wins; the head entry counts even while draining.
    always_comb begin
        w_byp1 = rf_data1_in;
        w_byp2 = rf_data2_in;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (CW'(i) < w_cnt) begin
                if (r_rd[w_idx] == rs1_in) w_byp1 = r_data[w_idx];
                if (r_rd[w_idx] == rs2_in) w_byp2 = r_data[w_idx];
            end
        end
        if (rs1_in == '0) w_byp1 = '0;
        if (rs2_in == '0) w_byp2 = '0;
    end

endmodule

// File: tb/tb_reg_wb_buffer.sv
// Directed bench for reg_wb_buffer: inputs change 1ns after the rising edge, outputs are checked 1ns later.
module tb_reg_wb_buffer;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        wb_valid_in;
    logic [4:0]  wb_rd_in;
    logic [63:0] wb_data_in;
    logic        wb_ready_out;
    logic        drain_en_in;
    logic        rf_write_en;
    logic [4:0]  rf_rd;
    logic [63:0] rf_data_write;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic [63:0] rf_data1_in;
    logic [63:0] rf_data2_in;
    logic [63:0] reg_data1_out;
    logic [63:0] reg_data2_out;
    logic [2:0]  count_out;

    int n_cmp = 0;
    int n_err = 0;

    reg_wb_buffer dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .wb_valid_in   (wb_valid_in),
        .wb_rd_in      (wb_rd_in),
        .wb_data_in    (wb_data_in),
        .wb_ready_out  (wb_ready_out),
        .drain_en_in   (drain_en_in),
        .rf_write_en   (rf_write_en),
        .rf_rd         (rf_rd),
        .rf_data_write (rf_data_write),
        .rs1_in        (rs1_in),
        .rs2_in        (rs2_in),
        .rf_data1_in   (rf_data1_in),
        .rf_data2_in   (rf_data2_in),
        .reg_data1_out (reg_data1_out),
        .reg_data2_out (reg_data2_out),
        .count_out     (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic offer(input logic v, input logic [4:0] rd, input logic [63:0] d);
        wb_valid_in = v;
        wb_rd_in    = rd;
        wb_data_in  = d;
    endtask

    initial begin
        reset = 1'b1;
        offer(1'b0, 5'd0, 64'h0);
        drain_en_in = 1'b1;
        rs1_in = 5'd3;
        rs2_in = 5'd0;
        rf_data1_in = 64'h1234;
        rf_data2_in = 64'h5678;

        // Reset state
        tick();
        tick();
        settle();
        chk("rst_count", 64'(count_out), 64'd0);
        chk("rst_ready", 64'(wb_ready_out), 64'd1);
        chk("rst_wen", 64'(rf_write_en), 64'd0);
        chk("rst_rd1_pass", reg_data1_out, 64'h1234);
        chk("rst_rd2_zero", reg_data2_out, 64'h0);
        reset = 1'b0;

        // Single push from empty drains the next cycle
        tick();
        offer(1'b1, 5'd5, 64'hAA);
        rs1_in = 5'd5;
        settle();
        chk("p1_ready", 64'(wb_ready_out), 64'd1);
        chk("p1_wen_empty", 64'(rf_write_en), 64'd0);
        chk("p1_no_early_byp", reg_data1_out, 64'h1234);
        tick();
        offer(1'b0, 5'd0, 64'h0);
        settle();
        chk("p1_wen", 64'(rf_write_en), 64'd1);
        chk("p1_rd", 64'(rf_rd), 64'd5);
        chk("p1_data", rf_data_write, 64'hAA);
        chk("p1_count", 64'(count_out), 64'd1);
        chk("p1_head_byp", reg_data1_out, 64'hAA);
        tick();
        settle();
        chk("p1_drained", 64'(count_out), 64'd0);
        chk("p1_wen_off", 64'(rf_write_en), 64'd0);

        // rd=0 offer is accepted and dropped
        offer(1'b1, 5'd0, 64'hFF);
        settle();
        chk("z_ready", 64'(wb_ready_out), 64'd1);
        tick();
        offer(1'b0, 5'd0, 64'h0);
        settle();
        chk("z_count", 64'(count_out), 64'd0);
        chk("z_wen", 64'(rf_write_en), 64'd0);

        // Fill with drain held, then drain in order
        drain_en_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            offer(1'b1, 5'(k), 64'h10 + 64'(k));
            tick();
        end
        offer(1'b1, 5'd9, 64'h99);
        rs1_in = 5'd3;
        settle();
        chk("f_count", 64'(count_out), 64'd4);
        chk("f_ready", 64'(wb_ready_out), 64'd0);
        chk("f_wen_held", 64'(rf_write_en), 64'd0);
        chk("f_byp3", reg_data1_out, 64'h13);
        tick();
        offer(1'b0, 5'd0, 64'h0);
        settle();
        chk("f_fifth_refused", 64'(count_out), 64'd4);
        drain_en_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk("d_wen", 64'(rf_write_en), 64'd1);
            chk("d_rd", 64'(rf_rd), 64'(k));
            chk("d_data", rf_data_write, 64'h10 + 64'(k));
            tick();
        end
        settle();
        chk("d_empty", 64'(count_out), 64'd0);
        chk("d_wen_off", 64'(rf_write_en), 64'd0);

        // Duplicate rd: youngest wins, index 0 reads zero
        drain_en_in = 1'b0;
        offer(1'b1, 5'd7, 64'h11);
        tick();
        offer(1'b1, 5'd7, 64'h22);
        tick();
        offer(1'b0, 5'd0, 64'h0);
        rs1_in = 5'd7;
        rf_data1_in = 64'h0;
        rs2_in = 5'd0;
        rf_data2_in = 64'h55;
        settle();
        chk("dup_count", 64'(count_out), 64'd2);
        chk("dup_byp1", reg_data1_out, 64'h22);
        chk("dup_byp2_zero", reg_data2_out, 64'h0);

        // Full with drain enabled: refused, then push+pop holds count across pointer wrap
        offer(1'b1, 5'd8, 64'h33);
        tick();
        offer(1'b1, 5'd9, 64'h44);
        tick();
        offer(1'b1, 5'd10, 64'h66);
        drain_en_in = 1'b1;
        settle();
        chk("w_full_ready", 64'(wb_ready_out), 64'd0);
        chk("w_full_wen", 64'(rf_write_en), 64'd1);
        chk("w_full_rd", 64'(rf_rd), 64'd7);
        chk("w_full_data", rf_data_write, 64'h11);
        tick();
        settle();
        chk("w1_count", 64'(count_out), 64'd3);
        chk("w1_ready", 64'(wb_ready_out), 64'd1);
        chk("w1_rd", 64'(rf_rd), 64'd7);
        chk("w1_data", rf_data_write, 64'h22);
        chk("w1_byp", reg_data1_out, 64'h22);
        tick();
        offer(1'b1, 5'd11, 64'h77);
        rs1_in = 5'd10;
        settle();
        chk("w2_count", 64'(count_out), 64'd3);
        chk("w2_rd", 64'(rf_rd), 64'd8);
        chk("w2_data", rf_data_write, 64'h33);
        chk("w2_byp", reg_data1_out, 64'h66);
        tick();
        offer(1'b0, 5'd0, 64'h0);
        drain_en_in = 1'b0;
        settle();
        chk("w3_count", 64'(count_out), 64'd3);
        chk("w3_rd", 64'(rf_rd), 64'd9);
        chk("w3_data", rf_data_write, 64'h44);

        // Reset with three entries pending
        reset = 1'b1;
        drain_en_in = 1'b1;
        rf_data1_in = 64'hABC;
        settle();
        chk("r_during_count", 64'(count_out), 64'd0);
        chk("r_during_wen", 64'(rf_write_en), 64'd0);
        chk("r_during_ready", 64'(wb_ready_out), 64'd1);
        tick();
        reset = 1'b0;
        settle();
        chk("r_after_count", 64'(count_out), 64'd0);
        chk("r_after_wen", 64'(rf_write_en), 64'd0);
        chk("r_after_no_byp", reg_data1_out, 64'hABC);
        tick();
        settle();
        chk("r_after2_wen", 64'(rf_write_en), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_wb_buffer.md
REG_WB_BUFFER -- requirements
Module: reg_wb_buffer

Interface
REQ-001 SHALL have parameter REG_DATA_WIDTH_POW, default 6, data width = 1<<REG_DATA_WIDTH_POW (64).
REQ-002 SHALL have parameter REG_MEM_DEPTH_POW, default 5, register index width (32 registers).
REQ-003 SHALL have parameter BUF_DEPTH_POW, default 2, buffer depth = 1<<BUF_DEPTH_POW (4 entries).
REQ-004 SHALL have port clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port wb_valid_in  input  1  producer offers a write-back result.
REQ-007 SHALL have port wb_rd_in  input  REG_MEM_DEPTH_POW  destination register of offered result.
REQ-008 SHALL have port wb_data_in  input  REG_DATA_WIDTH  offered result data.
REQ-009 SHALL have port wb_ready_out  output  1  buffer accepts offer this cycle.
REQ-010 SHALL have port drain_en_in  input  1  register file write port available this cycle.
REQ-011 SHALL have port rf_write_en  output  1  write enable to register file.
REQ-012 SHALL have port rf_rd  output  REG_MEM_DEPTH_POW  register number to register file.
REQ-013 SHALL have port rf_data_write  output  REG_DATA_WIDTH  data to register file.
REQ-014 SHALL have ports rs1_in, rs2_in  input  REG_MEM_DEPTH_POW  read register numbers (also driven to register file).
REQ-015 SHALL have ports rf_data1_in, rf_data2_in  input  REG_DATA_WIDTH  register file read data for rs1_in/rs2_in.
REQ-016 SHALL have ports reg_data1_out, reg_data2_out  output  REG_DATA_WIDTH  bypass-corrected read data.
REQ-017 SHALL have port count_out  output  BUF_DEPTH_POW+1  number of pending entries.

Function
REQ-018 SHALL be a circular FIFO with head/tail pointers of BUF_DEPTH_POW bits, wrapping modulo depth.
REQ-019 wb_ready_out SHALL be 1 iff count_out < depth (full => 0, regardless of drain).
REQ-020 Push SHALL occur when wb_valid_in && wb_ready_out && wb_rd_in != 0; entry {rd,data} written at tail, tail+1.
REQ-021 Offer with wb_rd_in == 0 SHALL be handshaken (ready as per REQ-019) and discarded; count unchanged.
REQ-022 rf_write_en SHALL equal (count_out != 0) && drain_en_in, combinational; rf_rd/rf_data_write = head entry.
REQ-023 Pop SHALL occur at the edge where rf_write_en == 1; head+1.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 Latency: entry pushed at edge N SHALL appear at head no earlier than cycle after N; with empty buffer and drain_en_in=1, rf_write_en=1 in cycle N+1.
REQ-026 Entries SHALL drain in push order; at most one write per cycle.
REQ-027 reg_data1_out SHALL be 0 if rs1_in == 0; else data of youngest pending entry with rd == rs1_in; else rf_data1_in. Same for port 2.
REQ-028 Bypass SHALL include the head entry being written this cycle; an entry pushed this cycle SHALL NOT be bypassed until next cycle.
REQ-029 Pending entries SHALL NOT be merged or reordered; duplicate rd entries each drain.
REQ-030 drain_en_in == 0 SHALL hold all entries; pushes continue until full.

Reset
REQ-031 reset SHALL clear head, tail, count to 0 at the next rising edge; entries discarded, not written.
REQ-032 During and after reset: count_out=0, wb_ready_out=1, rf_write_en=0; reg_data outputs pass through rf_data inputs (0 for index 0).
REQ-033 Reset SHALL take priority over simultaneous push/pop in the same cycle.
REQ-034 Entry storage contents need not be reset; bypass SHALL match only entries within count.

Verification
REQ-035 Push rd=5,data=0xAA with drain_en_in=1 from empty -> next cycle rf_write_en=1, rf_rd=5, rf_data_write=0xAA; following cycle count_out=0.
REQ-036 drain_en_in=0, push rd=1..4 -> count_out=4, wb_ready_out=0; fifth offer not accepted; drain_en_in=1 -> writes 1,2,3,4 in order over 4 cycles.
REQ-037 Pending rd=7 0x11 then rd=7 0x22, drain held, rs1_in=7, rf_data1_in=0x00 -> reg_data1_out=0x22; rs2_in=0 -> reg_data2_out=0.
REQ-038 Push rd=0,data=0xFF -> wb_ready_out=1, count_out unchanged, no rf_write_en.
REQ-039 Full buffer, drain_en_in=1, wb_valid_in=1 -> offer refused that cycle; next cycle count=3, ready=1; push+pop keeps count=3 with pointers wrapping past depth.
REQ-040 Three entries pending, assert reset one cycle -> count_out=0, rf_write_en=0 next cycle, no stale entry written.
